// File: rtl/sram_mem_arbiter_if.sv
// SRAM-like bus bundle between the two CPU requesters, the arbiter and the slave.
// slave: arbiter side; master: requester/memory side (testbench or top-level glue).
interface sram_mem_arbiter_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_wstrb,
    input  inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb,
    input  data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb,
    output mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_wr, inst_size, inst_wstrb,
    output inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb,
    output data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb,
    input  mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_mem_arbiter.sv
// Inst/data arbiter onto one SRAM-like port, with in-order
// response routing through a small owner-ID FIFO.
module sram_mem_arbiter #(
  parameter int OUTS_DEPTH = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic clk,
  input  logic resetn,
  sram_mem_arbiter_if.slave bus,
  output logic resp_err
);
  localparam int AW = $clog2(OUTS_DEPTH);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  logic            lock;
  logic            lock_id;
  logic            sel;
  logic            sel_req;
  logic            starve_win;
  logic            fifo_full;
  logic            fifo_empty;
  logic            accept;
  logic            pop;
  logic            head;
  logic [SW-1:0]   starve_cnt;
  logic [AW:0]     count;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [OUTS_DEPTH-1:0] ids;

  assign starve_win = bus.inst_req & bus.data_req
                    & (starve_cnt == SW'(STARVE_LIM));

  always_comb begin
    sel = SEL_I;
    priority case (1'b1)
      lock:         sel = lock_id;
      starve_win:   sel = SEL_I;
      bus.data_req: sel = SEL_D;
      default:      sel = SEL_I;
    endcase
  end

  assign fifo_full  = (count == (AW+1)'(OUTS_DEPTH));
  assign fifo_empty = (count == '0);
  assign sel_req    = sel ? bus.data_req : bus.inst_req;

  assign bus.mem_req   = sel_req & ~fifo_full;
  assign bus.mem_wr    = sel ? bus.data_wr    : bus.inst_wr;
  assign bus.mem_size  = sel ? bus.data_size  : bus.inst_size;
  assign bus.mem_wstrb = sel ? bus.data_wstrb : bus.inst_wstrb;
  assign bus.mem_addr  = sel ? bus.data_addr  : bus.inst_addr;
  assign bus.mem_wdata = sel ? bus.data_wdata : bus.inst_wdata;

  assign accept = bus.mem_req & bus.mem_addr_ok;
  assign bus.inst_addr_ok = accept & (sel == SEL_I);
  assign bus.data_addr_ok = accept & (sel == SEL_D);

  // Slave returns responses in order; the FIFO head names the owner.
  assign pop  = bus.mem_data_ok & ~fifo_empty;
  assign head = ids[rptr];
  assign bus.inst_data_ok = pop & (head == SEL_I);
  assign bus.data_data_ok = pop & (head == SEL_D);
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock       <= 1'b0;
      lock_id    <= SEL_I;
      starve_cnt <= '0;
      count      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      ids        <= '0;
      resp_err   <= 1'b0;
    end else begin
      // A request the slave may have sampled must not change until taken.
      if (accept) begin
        lock <= 1'b0;
      end else if (bus.mem_req) begin
        lock    <= 1'b1;
        lock_id <= sel;
      end

      if (!bus.inst_req || (accept && sel == SEL_I)) begin
        starve_cnt <= '0;
      end else if (bus.data_req && sel == SEL_D &&
                   starve_cnt != SW'(STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (accept) begin
        ids[wptr] <= sel;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end

      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (bus.mem_data_ok && fifo_empty) begin
        resp_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Directed checks for sram_mem_arbiter: grants, lock,
// starvation, FIFO full/wrap, stray responses and async reset.
module tb_sram_mem_arbiter;
  logic clk;
  logic resetn;
  logic resp_err;
  int   total;
  int   bad;

  sram_mem_arbiter_if bus ();

  sram_mem_arbiter #(
    .OUTS_DEPTH (4),
    .STARVE_LIM (3)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .resp_err (resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.inst_req    = 1'b0;
    bus.inst_wr     = 1'b0;
    bus.inst_size   = 2'd2;
    bus.inst_wstrb  = 4'h0;
    bus.inst_addr   = 32'h0;
    bus.inst_wdata  = 32'h0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_size   = 2'd2;
    bus.data_wstrb  = 4'h0;
    bus.data_addr   = 32'h0;
    bus.data_wdata  = 32'h0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'h0;
  endtask

  logic [7:0] gexp;
  logic [3:0] own;

  initial begin
    total = 0;
    bad   = 0;
    idle();
    resetn = 1'b0;
    #12;
    resetn = 1'b1;
    tick();

    // reset / idle
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_iaok", 32'(bus.inst_addr_ok), 0);
    chk("rst_daok", 32'(bus.data_addr_ok), 0);
    chk("rst_idok", 32'(bus.inst_data_ok), 0);
    chk("rst_ddok", 32'(bus.data_data_ok), 0);
    chk("rst_err", 32'(resp_err), 0);
    tick();

    // single inst read
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'h1C00_0000;
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("t1_mem_req", 32'(bus.mem_req), 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h1C00_0000);
    chk("t1_iaok", 32'(bus.inst_addr_ok), 1);
    chk("t1_daok", 32'(bus.data_addr_ok), 0);
    tick();
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    #1;
    chk("t1_idok_c1", 32'(bus.inst_data_ok), 0);
    tick();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h0280_0000;
    #1;
    chk("t1_idok", 32'(bus.inst_data_ok), 1);
    chk("t1_irdata", bus.inst_rdata, 32'h0280_0000);
    chk("t1_ddok", 32'(bus.data_data_ok), 0);
    tick();
    bus.mem_data_ok = 1'b0;

    // both held: D,D,D,I,D,D,D,I ; responses one cycle behind
    gexp = 8'b0111_0111;
    bus.inst_req    = 1'b1;
    bus.data_req    = 1'b1;
    bus.inst_addr   = 32'h0000_1000;
    bus.data_addr   = 32'h0000_2000;
    bus.mem_addr_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.mem_data_ok = (i > 0);
      #1;
      chk($sformatf("t2_daok%0d", i), 32'(bus.data_addr_ok), 32'(gexp[i]));
      chk($sformatf("t2_iaok%0d", i), 32'(bus.inst_addr_ok), 32'(!gexp[i]));
      chk($sformatf("t2_addr%0d", i), bus.mem_addr,
          gexp[i] ? 32'h0000_2000 : 32'h0000_1000);
      if (i > 0) begin
        chk($sformatf("t2_ddok%0d", i), 32'(bus.data_data_ok), 32'(gexp[i-1]));
        chk($sformatf("t2_idok%0d", i), 32'(bus.inst_data_ok), 32'(!gexp[i-1]));
      end
      tick();
    end
    bus.inst_req    = 1'b0;
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    #1;
    chk("t2_idok_last", 32'(bus.inst_data_ok), 1);
    chk("t2_ddok_last", 32'(bus.data_data_ok), 0);
    tick();
    bus.mem_data_ok = 1'b0;

    // lock: data held un-acked while inst rises
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_3000;
    bus.inst_addr = 32'h0000_4000;
    #1;
    chk("t3_req_c0", 32'(bus.mem_req), 1);
    chk("t3_addr_c0", bus.mem_addr, 32'h0000_3000);
    chk("t3_daok_c0", 32'(bus.data_addr_ok), 0);
    tick();
    bus.inst_req = 1'b1;
    #1;
    chk("t3_addr_c1", bus.mem_addr, 32'h0000_3000);
    chk("t3_iaok_c1", 32'(bus.inst_addr_ok), 0);
    tick();
    #1;
    chk("t3_addr_c2", bus.mem_addr, 32'h0000_3000);
    tick();
    bus.mem_addr_ok = 1'b1;
    #1;
    chk("t3_daok_c3", 32'(bus.data_addr_ok), 1);
    chk("t3_addr_c3", bus.mem_addr, 32'h0000_3000);
    tick();
    #1;
    chk("t3_iaok_c4", 32'(bus.inst_addr_ok), 1);
    chk("t3_addr_c4", bus.mem_addr, 32'h0000_4000);
    tick();
    bus.inst_req    = 1'b0;
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    #1;
    chk("t3_ddok", 32'(bus.data_data_ok), 1);
    tick();
    #1;
    chk("t3_idok", 32'(bus.inst_data_ok), 1);
    tick();
    bus.mem_data_ok = 1'b0;

    // fill FIFO with 4 data accepts
    bus.data_req    = 1'b1;
    bus.data_addr   = 32'h0000_5000;
    bus.mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t4_fill%0d", i), 32'(bus.data_addr_ok), 1);
      tick();
    end
    // full: response and new inst request together
    bus.data_req    = 1'b0;
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'h0000_6000;
    bus.mem_data_ok = 1'b1;
    #1;
    chk("t4_full_req", 32'(bus.mem_req), 0);
    chk("t4_full_iaok", 32'(bus.inst_addr_ok), 0);
    chk("t4_pop_d0", 32'(bus.data_data_ok), 1);
    tick();
    bus.mem_data_ok = 1'b0;
    #1;
    chk("t4_refill_req", 32'(bus.mem_req), 1);
    chk("t4_refill_iaok", 32'(bus.inst_addr_ok), 1);
    tick();
    bus.mem_data_ok = 1'b1;
    #1;
    chk("t4_full2_req", 32'(bus.mem_req), 0);
    chk("t4_pop_d1", 32'(bus.data_data_ok), 1);
    tick();
    #1;
    chk("t4_pushpop_iaok", 32'(bus.inst_addr_ok), 1);
    chk("t4_pop_d2", 32'(bus.data_data_ok), 1);
    tick();
    bus.inst_req    = 1'b0;
    bus.data_req    = 1'b1;
    bus.mem_data_ok = 1'b0;
    #1;
    chk("t4_last_daok", 32'(bus.data_addr_ok), 1);
    tick();
    #1;
    chk("t4_full3_req", 32'(bus.mem_req), 0);
    tick();
    // drain wrapped FIFO: D, I, I, D
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b1;
    own = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      bus.mem_rdata = 32'hA000_0000 + 32'(i);
      #1;
      chk($sformatf("t4_drain_d%0d", i), 32'(bus.data_data_ok), 32'(own[i]));
      chk($sformatf("t4_drain_i%0d", i), 32'(bus.inst_data_ok), 32'(!own[i]));
      chk($sformatf("t4_drain_rd%0d", i), bus.data_rdata,
          32'hA000_0000 + 32'(i));
      tick();
    end

    // stray response with empty FIFO
    #1;
    chk("t5_stray_i", 32'(bus.inst_data_ok), 0);
    chk("t5_stray_d", 32'(bus.data_data_ok), 0);
    chk("t5_err_pre", 32'(resp_err), 0);
    tick();
    bus.mem_data_ok = 1'b0;
    #1;
    chk("t5_err_set", 32'(resp_err), 1);
    tick();
    #1;
    chk("t5_err_hold", 32'(resp_err), 1);

    // build count=2, lock=1 (on data), then async reset
    bus.inst_req    = 1'b1;
    bus.inst_addr   = 32'h0000_7000;
    bus.mem_addr_ok = 1'b1;
    tick();
    bus.inst_req  = 1'b0;
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_8000;
    tick();
    bus.mem_addr_ok = 1'b0;
    #1;
    chk("t6_lock_req", 32'(bus.mem_req), 1);
    tick();
    #2;
    resetn = 1'b0;
    idle();
    #1;
    chk("t6_async_err", 32'(resp_err), 0);
    chk("t6_async_req", 32'(bus.mem_req), 0);
    tick();
    resetn = 1'b1;
    tick();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h0000_9000;
    #1;
    chk("t6_nolock_req", 32'(bus.mem_req), 1);
    chk("t6_nolock_addr", bus.mem_addr, 32'h0000_9000);
    tick();
    bus.inst_req    = 1'b0;
    bus.mem_addr_ok = 1'b1;
    bus.mem_data_ok = 1'b1;
    #1;
    chk("t6_empty_idok", 32'(bus.inst_data_ok), 0);
    chk("t6_empty_ddok", 32'(bus.data_data_ok), 0);
    tick();
    idle();
    #1;
    chk("t6_err_again", 32'(resp_err), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_mem_arbiter.md
Name: sram_mem_arbiter

Overview:
- Shares one SRAM-like memory port between the CPU instruction requester (IF stage) and data requester (EXE/MEM stages).
- Both requesters use the same req/addr_ok/data_ok protocol as the CPU core.
- Arbitrates address-phase requests (data has priority, with an inst anti-starvation override).
- Tracks outstanding transactions in an in-order ID FIFO and routes each slave data_ok/rdata back to its owner.
- Sits between mycpu core and the downstream AXI bridge/memory.

Parameters:
OUTS_DEPTH, 4, max outstanding accepted transactions (power of 2, ≥2)
STARVE_LIM, 3, consecutive cycles inst may be denied while requesting before it gets priority

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  inst request valid
inst_wr  in  1  inst write (normally 0)
inst_size  in  2  inst access size
inst_wstrb  in  4  inst byte strobes
inst_addr  in  32  inst address
inst_wdata  in  32  inst write data
inst_addr_ok  out  1  inst request accepted
inst_data_ok  out  1  inst response valid
inst_rdata  out  32  inst read data
data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data request fields, same meaning as the inst fields
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
data_rdata  out  32  data read data
mem_req  out  1  request to slave
mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  muxed request fields
mem_addr_ok  in  1  slave accepted request
mem_data_ok  in  1  slave response (in order)
mem_rdata  in  32  slave read data
resp_err  out  1  sticky: mem_data_ok received with no outstanding transaction

Behaviour:
- Reset (async, resetn=0): lock=0, lock_id=0, FIFO count/pointers=0, starve_cnt=0, resp_err=0.
- After reset, all combinational outputs are 0 when inputs are idle.

Grant selection (combinational):
- If lock=1: sel=lock_id.
- Else if both requesting and starve_cnt==STARVE_LIM: sel=inst.
- Else if data_req: sel=data.
- Else: sel=inst.
- mem_req = (selected requester's req) & ~fifo_full.
- mem_* fields mux from sel.
- When fifo_full, mem_req=0 even if lock=1. Locked requests therefore stall, never switch.

Handshake:
- Accept = mem_req & mem_addr_ok.
- The selected requester's addr_ok = accept; the other requester's addr_ok = 0.
- mem_addr_ok is ignored when mem_req=0.

Lock:
- mem_req=1 & ~mem_addr_ok: lock<=1, lock_id<=sel. The slave may have sampled the request, so it must stay stable until acceptance.
- Accept: lock<=0.

Starvation counter:
- inst_req & data_req & sel==data & no accept of inst: starve_cnt increments, saturating at STARVE_LIM.
- Inst accepted, or inst_req=0: starve_cnt<=0.

ID FIFO:
- Depth OUTS_DEPTH, 1-bit entries (0=inst, 1=data).
- Push sel on accept; pop on mem_data_ok when count>0.
- Simultaneous push and pop: count unchanged; entries stay correct, including at pointer wrap-around.
- fifo_full = (count==OUTS_DEPTH).

Response routing (combinational, zero latency):
- inst_data_ok = mem_data_ok & count>0 & head==0.
- data_data_ok = mem_data_ok & count>0 & head==1.
- inst_rdata = data_rdata = mem_rdata.
- mem_data_ok with count==0: no data_ok asserted, no pop, resp_err<=1 (cleared only by reset).

Latency:
- Arbiter adds 0 cycles on both address and response paths.
- Throughput is 1 accept per cycle.

Test Plan:
- Single inst read, addr 0x1C000000; slave addr_ok same cycle, data_ok 2 cycles later with 0x02800000 -> inst_addr_ok=1 in cycle 0; inst_data_ok=1, inst_rdata=0x02800000 in cycle 2; data_data_ok never asserted.
- inst_req and data_req both held, slave addr_ok always 1 -> grants D,D,D,I,D,D,D,I (STARVE_LIM=3); FIFO order matches; responses routed accordingly.
- data_req asserted with mem_addr_ok=0 for 3 cycles while inst_req rises in cycle 1 -> mem_addr stays the data address all 3 cycles; data accepted in cycle 3; inst served in cycle 4.
- 4 accepts with no data_ok (FIFO full), then mem_data_ok in the same cycle as a new request -> mem_req=0 that cycle; next cycle mem_req=1; count stays 4 after the following accept+pop.
- mem_data_ok pulse with FIFO empty -> no *_data_ok, resp_err=1 and holds; resetn low mid-transfer (count=2, lock=1) -> all state cleared asynchronously, resp_err=0.
